// File: rtl/fpu_result_stage.sv
// Result FIFO for the FPU subtractor. Each accepted result is classified,
// optionally NaN-canonicalised and stored with its class and NaN flag.
// Sticky and saturating counters track NaN traffic.
module fpu_result_stage #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          CANON_NAN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_result,
    input  logic                     in_nan,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [2:0]               out_class,
    output logic                     out_nan,
    output logic                     nan_sticky,
    input  logic                     clr_sticky,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               nan_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] QNAN_CANON = 32'h7FC00000;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'b000,
        CLS_SUB  = 3'b001,
        CLS_NORM = 3'b010,
        CLS_INF  = 3'b011,
        CLS_QNAN = 3'b100,
        CLS_SNAN = 3'b101
    } cls_e;

    logic [31:0]   r_data [DEPTH];
    cls_e          r_cls  [DEPTH];
    logic          r_nanf [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_sticky;
    logic [7:0]    r_nan_count;

    logic [7:0]    w_exp;
    logic [22:0]   w_man;
    cls_e          w_cls;
    cls_e          w_st_cls;
    logic [31:0]   w_st_val;
    logic          w_is_nan;
    logic          w_push;
    logic          w_pop;
    logic          w_nan_push;

    assign in_ready   = (r_count < FULL);
    assign out_valid  = (r_count != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_nan_push = w_push && w_is_nan;

    assign out_result = out_valid ? r_data[r_rptr] : '0;
    assign out_class  = out_valid ? r_cls[r_rptr]  : '0;
    assign out_nan    = out_valid ? r_nanf[r_rptr] : 1'b0;
    assign count      = r_count;
    assign nan_sticky = r_sticky;
    assign nan_count  = r_nan_count;

    // Classify the incoming result and form the value/class to store.
    always_comb begin
        w_exp    = in_result[30:23];
        w_man    = in_result[22:0];
        w_cls    = CLS_NORM;
        if (w_exp == 8'h00) begin
            w_cls = (w_man == '0) ? CLS_ZERO : CLS_SUB;
        end else if (w_exp == 8'hFF) begin
            if (w_man == '0)
                w_cls = CLS_INF;
            else if (w_man[22])
                w_cls = CLS_QNAN;
            else
                w_cls = CLS_SNAN;
        end
        w_is_nan = in_nan || (w_cls == CLS_QNAN) || (w_cls == CLS_SNAN);
        w_st_cls = w_cls;
        w_st_val = in_result;
        if (w_is_nan) begin
            // A flagged result with a non-NaN encoding is reported as quiet NaN.
            if ((w_cls != CLS_QNAN) && (w_cls != CLS_SNAN))
                w_st_cls = CLS_QNAN;
            if (CANON_NAN) begin
                w_st_val = QNAN_CANON;
                w_st_cls = CLS_QNAN;
            end
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= w_st_val;
            r_cls[r_wptr]  <= w_st_cls;
            r_nanf[r_wptr] <= w_is_nan;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NaN sticky flag and saturating NaN counter; a same-cycle NaN push beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky    <= 1'b0;
            r_nan_count <= '0;
        end else begin
            if (w_nan_push)
                r_sticky <= 1'b1;
            else if (clr_sticky)
                r_sticky <= 1'b0;

            if (clr_sticky)
                r_nan_count <= w_nan_push ? 8'd1 : 8'd0;
            else if (w_nan_push && (r_nan_count != 8'hFF))
                r_nan_count <= r_nan_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fpu_result_stage.sv
// Testbench for fpu_result_stage: two instances (canonicalising and raw NaN)
// share stimulus; a queue scoreboard holds expected entries for both.
module tb_fpu_result_stage;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NV    = 14;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_nan, out_ready, clr_sticky;
    logic [31:0] in_result;

    logic          ir1, ov1, on1, st1, ir0, ov0, on0, st0;
    logic [31:0]   or1, or0;
    logic [2:0]    oc1, oc0;
    logic [CW-1:0] cnt1, cnt0;
    logic [7:0]    nc1, nc0;

    always #5 clk = ~clk;

    fpu_result_stage #(.DEPTH(DEPTH), .CANON_NAN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
        .in_nan(in_nan), .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready),
        .out_result(or1), .out_class(oc1), .out_nan(on1), .nan_sticky(st1),
        .clr_sticky(clr_sticky), .count(cnt1), .nan_count(nc1)
    );

    fpu_result_stage #(.DEPTH(DEPTH), .CANON_NAN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
        .in_nan(in_nan), .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready),
        .out_result(or0), .out_class(oc0), .out_nan(on0), .nan_sticky(st0),
        .clr_sticky(clr_sticky), .count(cnt0), .nan_count(nc0)
    );

    typedef struct {
        logic [31:0] din;
        logic        nin;
        logic [31:0] r1;
        logic [2:0]  c1;
        logic [31:0] r0;
        logic [2:0]  c0;
    } vec_t;

    typedef struct {
        logic [31:0] r1;
        logic [2:0]  c1;
        logic [31:0] r0;
        logic [2:0]  c0;
        logic        n;
    } exp_t;

    vec_t tbl [NV];
    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;
    int   mcount = 0;
    int   mncnt  = 0;
    logic msticky = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic check_state();
        exp_t e;
        chk("in_ready",   32'(ir1), 32'(mcount < DEPTH));
        chk("out_valid",  32'(ov1), 32'(mcount != 0));
        chk("count",      32'(cnt1), 32'(mcount));
        chk("nan_sticky", 32'(st1), 32'(msticky));
        chk("nan_count",  32'(nc1), 32'(mncnt));
        chk("raw_count",  32'(cnt0), 32'(mcount));
        chk("raw_valid",  32'(ov0), 32'(mcount != 0));
        chk("raw_ready",  32'(ir0), 32'(mcount < DEPTH));
        chk("raw_sticky", 32'(st0), 32'(msticky));
        chk("raw_nan_count", 32'(nc0), 32'(mncnt));
        if (mcount != 0) begin
            e = sbq[0];
            chk("out_result", or1, e.r1);
            chk("out_class",  32'(oc1), 32'(e.c1));
            chk("out_nan",    32'(on1), 32'(e.n));
            chk("raw_result", or0, e.r0);
            chk("raw_class",  32'(oc0), 32'(e.c0));
            chk("raw_nan",    32'(on0), 32'(e.n));
        end else begin
            chk("idle_result", or1 | or0, 32'h0);
            chk("idle_class",  32'(oc1 | oc0), 32'h0);
            chk("idle_nan",    32'(on1 | on0), 32'h0);
        end
    endtask

    // One clock: drive inputs, check pre-edge state, advance the model, step the clock.
    task automatic cycle(input logic rs, input logic v, input int idx,
                         input logic ordy, input logic clr);
        logic pushm, popm, nanp;
        exp_t e;
        rst        = rs;
        in_valid   = v;
        in_result  = tbl[idx].din;
        in_nan     = tbl[idx].nin;
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        check_state();
        pushm = v && (mcount < DEPTH);
        popm  = ordy && (mcount != 0);
        nanp  = pushm && (tbl[idx].c0 >= 3'd4);
        if (rs) begin
            sbq.delete();
            msticky = 1'b0;
            mncnt   = 0;
        end else begin
            if (popm) void'(sbq.pop_front());
            if (pushm) begin
                e.r1 = tbl[idx].r1; e.c1 = tbl[idx].c1;
                e.r0 = tbl[idx].r0; e.c0 = tbl[idx].c0;
                e.n  = (tbl[idx].c0 >= 3'd4);
                sbq.push_back(e);
            end
            if (nanp) msticky = 1'b1;
            else if (clr) msticky = 1'b0;
            if (clr) mncnt = nanp ? 1 : 0;
            else if (nanp && mncnt < 255) mncnt++;
        end
        mcount = sbq.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           din            nin   r1 (canon)     c1    r0 (raw)       c0
        tbl[0]  = '{32'h40EB3333, 1'b0, 32'h40EB3333, 3'd2, 32'h40EB3333, 3'd2};
        tbl[1]  = '{32'hC0FCCCCD, 1'b0, 32'hC0FCCCCD, 3'd2, 32'hC0FCCCCD, 3'd2};
        tbl[2]  = '{32'h7FC00001, 1'b1, 32'h7FC00000, 3'd4, 32'h7FC00001, 3'd4};
        tbl[3]  = '{32'h00000000, 1'b0, 32'h00000000, 3'd0, 32'h00000000, 3'd0};
        tbl[4]  = '{32'h80000000, 1'b0, 32'h80000000, 3'd0, 32'h80000000, 3'd0};
        tbl[5]  = '{32'h00000001, 1'b0, 32'h00000001, 3'd1, 32'h00000001, 3'd1};
        tbl[6]  = '{32'h807FFFFF, 1'b0, 32'h807FFFFF, 3'd1, 32'h807FFFFF, 3'd1};
        tbl[7]  = '{32'h7F800000, 1'b0, 32'h7F800000, 3'd3, 32'h7F800000, 3'd3};
        tbl[8]  = '{32'hFF800000, 1'b0, 32'hFF800000, 3'd3, 32'hFF800000, 3'd3};
        tbl[9]  = '{32'h7F800001, 1'b0, 32'h7FC00000, 3'd4, 32'h7F800001, 3'd5};
        tbl[10] = '{32'hFFC00000, 1'b0, 32'h7FC00000, 3'd4, 32'hFFC00000, 3'd4};
        tbl[11] = '{32'h3F800000, 1'b1, 32'h7FC00000, 3'd4, 32'h3F800000, 3'd4};
        tbl[12] = '{32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 3'd2, 32'h7F7FFFFF, 3'd2};
        tbl[13] = '{32'h80800000, 1'b0, 32'h80800000, 3'd2, 32'h80800000, 3'd2};

        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_nan = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0);

        // Single push into empty FIFO, then drain.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);

        // Ordered pair with a flagged NaN, held then drained.
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Whole table streamed with varying consumer readiness.
        for (int i = 0; i < NV; i++)
            cycle(0, 1, i, (i % 3) != 0, 0);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(0, 0, 0, 1, 0);

        // Fill to full; extra in_valid dropped; one pop reopens the input.
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(0, 1, (i + 3) % NV, 0, 0);
        cycle(0, 1, 7, 1, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 0, 0, 1, 0);

        // count=2 with simultaneous push/pop across several pointer wraps.
        cycle(0, 1, 12, 0, 0);
        cycle(0, 1, 13, 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++)
            cycle(0, 1, (i * 5) % NV, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // NaN counter saturation, then clear together with a NaN push.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 260; i++)
            cycle(0, 1, 9, 1, 0);
        cycle(0, 1, 9, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);

        // Reset while draining with count=3.
        cycle(0, 1, 2, 0, 0);
        cycle(0, 1, 4, 0, 0);
        cycle(0, 1, 6, 0, 0);
        cycle(1, 1, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 97) == 0, $urandom % 2, $urandom % NV,
                  ($urandom % 3) != 0, ($urandom % 29) == 0);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_result_stage.md
FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

Interface
REQ-001 Parameter DEPTH, default 4: number of result FIFO entries; power of two, 2 to 16.
REQ-002 Parameter CANON_NAN, default 1: when 1, every stored NaN is replaced by 32'h7FC00000.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  subtractor result present this cycle.
REQ-006 in_result  input  32  IEEE-754 single result from the subtractor (Result).
REQ-007 in_nan  input  1  subtractor NaN flag (NaN_error).
REQ-008 in_ready  output  1  stage can accept a result this cycle.
REQ-009 out_valid  output  1  head entry is available.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_result  output  32  head entry value.
REQ-012 out_class  output  3  head entry class: 000 zero, 001 subnormal, 010 normal, 011 infinity, 100 quiet NaN, 101 signalling NaN.
REQ-013 out_nan  output  1  head entry is a NaN.
REQ-014 nan_sticky  output  1  a NaN has been accepted since the last clear.
REQ-015 clr_sticky  input  1  clears nan_sticky and nan_count.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 nan_count  output  8  number of accepted NaN results, saturating.

Function
REQ-018 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-019 in_ready = (count < DEPTH); no combinational dependence on out_ready, so there is no push while full, even if a pop happens in the same cycle.
REQ-020 out_valid = (count != 0); out_result, out_class and out_nan come from registered storage at the read pointer, so they are stable while out_valid && !out_ready.
REQ-021 Latency: a push in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty; there is no same-cycle bypass.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-023 Read and write pointers wrap modulo DEPTH; count stays within 0..DEPTH.
REQ-024 Classification at push uses the exponent e=in_result[30:23] and mantissa m=in_result[22:0]: e=0,m=0 zero; e=0,m!=0 subnormal; e=255,m=0 infinity; e=255,m[22]=1 quiet NaN; e=255,m[22]=0,m!=0 signalling NaN; otherwise normal.
REQ-025 An entry is NaN if in_nan=1 or its class is 100/101; in_nan=1 with a non-NaN encoding forces class 100.
REQ-026 With CANON_NAN=1, a NaN entry stores 32'h7FC00000 and class 100; with CANON_NAN=0 the value is stored unmodified.
REQ-027 The sign bit of non-NaN results is preserved exactly, including -0 (32'h80000000, class 000).
REQ-028 nan_sticky is set on any NaN push; clr_sticky clears it; set and clear in the same cycle leave it set (set wins).
REQ-029 nan_count increments by one per NaN push and saturates at 255; clr_sticky loads 0, or 1 if a NaN push happens in the same cycle.
REQ-030 in_valid while in_ready=0 is ignored (the value is dropped, no state change); the upstream holds it.

Reset
REQ-031 When rst=1 at a clock edge: pointers=0, count=0, out_valid=0, in_ready=1 in the following cycle, nan_sticky=0, nan_count=0; stored data is don't-care.
REQ-032 Reset overrides any push, pop or clr_sticky in the same cycle, including mid-drain.
REQ-033 out_result, out_class and out_nan read 0 while count=0.

Verification
REQ-034 Push 32'h40EB3333 (7.35), in_nan=0, into an empty FIFO -> next cycle out_valid=1, out_result=40EB3333, out_class=010, out_nan=0, count=1.
REQ-035 Push 32'hC0FCCCCD (-7.9), then 32'h7FC00001 with in_nan=1, holding out_ready=0 -> entries read back in order: C0FCCCCD/010, then 7FC00000/100; nan_sticky=1, nan_count=1.
REQ-036 Push DEPTH entries with out_ready=0 -> in_ready=0, count=DEPTH; a further in_valid is dropped; one pop restores in_ready=1 the next cycle.
REQ-037 With count=2, push and pop in the same cycle -> count stays 2, FIFO order preserved across pointer wrap.
REQ-038 Push 32'h7F800001 (sNaN) with in_nan=0 and CANON_NAN=0 -> out_class=101, out_nan=1; 256 NaN pushes -> nan_count=255; clr_sticky together with a NaN push -> nan_sticky=1, nan_count=1.
REQ-039 Assert rst with count=3 during a pop -> next cycle count=0, out_valid=0, in_ready=1, nan_sticky=0.
